// File: rtl/hwacc_pkg.sv
// hwacc_pkg: shared types and constants for the accelerator-to-core path.
// Holds the dispatcher state enum, ctrl encoding and core count.
package hwacc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAY
  } state_t;

  localparam int NUM_CORES    = 2;
  localparam int CTRL_PAYLOAD = 0;

  function automatic logic [NUM_CORES-1:0] core_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/pkt_core_dispatch_if.sv
// pkt_core_dispatch_if: accelerator word stream in, dual-core FIFO bus out.
// slave = dispatcher view, master = accelerator/FIFO side view.
interface pkt_core_dispatch_if #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8
);
  import hwacc_pkg::*;

  logic [DATA_WIDTH-1:0] in_data;
  logic [CTRL_WIDTH-1:0] in_ctrl;
  logic                  in_wr;
  logic                  in_rdy;
  logic [NUM_CORES-1:0]  out_rdy;
  logic [DATA_WIDTH-1:0] out_data;
  logic [CTRL_WIDTH-1:0] out_ctrl;
  logic [NUM_CORES-1:0]  out_wr;

  modport slave (
    input  in_data, in_ctrl, in_wr, out_rdy,
    output in_rdy, out_data, out_ctrl, out_wr
  );

  modport master (
    output in_data, in_ctrl, in_wr, out_rdy,
    input  in_rdy, out_data, out_ctrl, out_wr
  );

endinterface

// File: rtl/pkt_core_dispatch_rr_pick2.sv
// rr_pick2: combinational 2-way round-robin pick.
// in: last, elig[1:0]; out: grant_idx, grant_valid.
module rr_pick2 (
  input  logic       last,
  input  logic [1:0] elig,
  output logic       grant_idx,
  output logic       grant_valid
);

  always_comb begin
    grant_idx   = ~last;
    grant_valid = 1'b0;
    if (elig[~last]) begin
      grant_idx   = ~last;
      grant_valid = 1'b1;
    end else if (elig[last]) begin
      grant_idx   = last;
      grant_valid = 1'b1;
    end
  end

endmodule

// File: rtl/pkt_core_dispatch.sv
// pkt_core_dispatch: routes each accelerator packet to one core FIFO.
// ports: clk, reset, bus (slave), core_en, pkt_cnt0/1, proto_err.
module pkt_core_dispatch
  import hwacc_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8
) (
  input  logic                    clk,
  input  logic                    reset,
  pkt_core_dispatch_if.slave      bus,
  input  logic [NUM_CORES-1:0]    core_en,
  output logic [15:0]             pkt_cnt0,
  output logic [15:0]             pkt_cnt1,
  output logic                    proto_err
);

  state_t                state;
  logic                  sel;
  logic                  last;
  logic [DATA_WIDTH-1:0] data_q;
  logic [CTRL_WIDTH-1:0] ctrl_q;
  logic [NUM_CORES-1:0]  wr_q;

  logic [NUM_CORES-1:0]  elig;
  logic                  grant_idx;
  logic                  grant_valid;
  logic                  in_rdy;
  logic                  acc;
  logic                  is_pay;

  assign elig   = core_en & bus.out_rdy;
  assign is_pay = bus.in_ctrl == CTRL_WIDTH'(CTRL_PAYLOAD);
  assign acc    = bus.in_wr & in_rdy;

  rr_pick2 u_pick (
    .last        (last),
    .elig        (elig),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  always_comb begin
    in_rdy = 1'b0;
    if (!reset) begin
      unique case (state)
        IDLE:     in_rdy = grant_valid;
        HDR, PAY: in_rdy = bus.out_rdy[sel];
        default:  in_rdy = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sel       <= 1'b0;
      last      <= 1'b1;
      data_q    <= '0;
      ctrl_q    <= '0;
      wr_q      <= '0;
      pkt_cnt0  <= '0;
      pkt_cnt1  <= '0;
      proto_err <= 1'b0;
    end else begin
      wr_q <= '0;
      if (bus.in_wr && !in_rdy)
        proto_err <= 1'b1;
      if (acc) begin
        unique case (state)
          IDLE: begin
            if (is_pay) begin
              proto_err <= 1'b1;
            end else begin
              sel    <= grant_idx;
              last   <= grant_idx;
              state  <= HDR;
              data_q <= bus.in_data;
              ctrl_q <= bus.in_ctrl;
              wr_q   <= core_onehot(grant_idx);
            end
          end
          HDR: begin
            data_q <= bus.in_data;
            ctrl_q <= bus.in_ctrl;
            wr_q   <= core_onehot(sel);
            if (is_pay)
              state <= PAY;
          end
          PAY: begin
            data_q <= bus.in_data;
            ctrl_q <= bus.in_ctrl;
            wr_q   <= core_onehot(sel);
            if (!is_pay) begin
              state <= IDLE;
              if (sel) pkt_cnt1 <= pkt_cnt1 + 16'd1;
              else     pkt_cnt0 <= pkt_cnt0 + 16'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.in_rdy   = in_rdy;
  assign bus.out_data = data_q;
  assign bus.out_ctrl = ctrl_q;
  assign bus.out_wr   = wr_q;

endmodule
